// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the CPU-to-UART bus bridge.
// The state encoding is used by the bridge FSM.
package uart_bridge_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    WR_WAIT_TBRE,
    WR_WAIT_TSRE,
    RD_WAIT,
    RD_PULSE,
    RD_RELEASE,
    DONE
  } bridgeStateT;

  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic STROBE_IDLE   = 1'b1;

endpackage

// File: rtl/uart_bus_bridge_sync2.sv
// Two-flop synchronizer with synchronous active-high reset, used to
// bring the asynchronous UART status flags into the clk domain.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// Sequences single-cycle CPU requests into rdn/wrn strobes on the shared
// ram1 data bus and waits on the synchronized UART status flags.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_we,
  input  logic [7:0] req_wdata,
  output logic       busy,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic       rx_ready,
  output logic       tx_ready,
  input  logic       tbre,
  input  logic       tsre,
  input  logic       dataReady,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       rdn,
  output logic       wrn,
  output logic       ram1_en,
  output logic       ram1_oe,
  output logic       ram1_we
);

  localparam logic [3:0]       PULSE_LAST    = 4'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  bridgeStateT      state;
  logic [3:0]       pulseCnt;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] waitNext;
  logic             timeoutHit;
  logic [2:0]       flagsSync;
  logic             tbreS;
  logic             tsreS;
  logic             dataReadyS;

  sync2 #(.WIDTH(3)) flagSync (
    .clk (clk),
    .rst (rst),
    .d   ({dataReady, tsre, tbre}),
    .q   (flagsSync)
  );

  assign tbreS      = flagsSync[0];
  assign tsreS      = flagsSync[1];
  assign dataReadyS = flagsSync[2];

  // RAM1 shares the bus but is never accessed through this bridge.
  assign ram1_en = 1'b1;
  assign ram1_oe = 1'b1;
  assign ram1_we = 1'b1;

  assign rx_ready = dataReadyS;
  assign tx_ready = tsreS && (state == IDLE);

  // Wait counter saturates so a very long stall cannot wrap back below the limit.
  always_comb begin
    waitNext   = (waitCnt == '1) ? waitCnt : waitCnt + 1'b1;
    timeoutHit = (TIMEOUT_CYCLES != 0) && (waitNext >= TIMEOUT_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pulseCnt   <= '0;
      waitCnt    <= '0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 8'h00;
      resp_err   <= 1'b0;
      data_out   <= 8'h00;
      data_oe    <= 1'b0;
      rdn        <= STROBE_IDLE;
      wrn        <= STROBE_IDLE;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            busy <= 1'b1;
            if (req_we) begin
              state    <= WR_SETUP;
              data_out <= req_wdata;
              data_oe  <= 1'b1;
            end else begin
              state   <= RD_WAIT;
              waitCnt <= '0;
            end
          end
        end
        WR_SETUP: begin
          state    <= WR_PULSE;
          wrn      <= STROBE_ACTIVE;
          pulseCnt <= '0;
        end
        WR_PULSE: begin
          if (pulseCnt == PULSE_LAST) begin
            state <= WR_HOLD;
            wrn   <= STROBE_IDLE;
          end else begin
            pulseCnt <= pulseCnt + 1'b1;
          end
        end
        WR_HOLD: begin
          state   <= WR_WAIT_TBRE;
          data_oe <= 1'b0;
          waitCnt <= '0;
        end
        WR_WAIT_TBRE: begin
          if (tbreS) begin
            state   <= WR_WAIT_TSRE;
            waitCnt <= '0;
          end else if (timeoutHit) begin
            state      <= DONE;
            busy       <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            waitCnt <= waitNext;
          end
        end
        WR_WAIT_TSRE: begin
          if (tsreS) begin
            state      <= DONE;
            busy       <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
          end else if (timeoutHit) begin
            state      <= DONE;
            busy       <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            waitCnt <= waitNext;
          end
        end
        RD_WAIT: begin
          if (dataReadyS) begin
            state    <= RD_PULSE;
            rdn      <= STROBE_ACTIVE;
            pulseCnt <= '0;
          end else if (timeoutHit) begin
            state      <= DONE;
            busy       <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            waitCnt <= waitNext;
          end
        end
        // The UART drives the bus while rdn is low; sample it on the last low cycle.
        RD_PULSE: begin
          if (pulseCnt == PULSE_LAST) begin
            state      <= RD_RELEASE;
            rdn        <= STROBE_IDLE;
            resp_rdata <= data_in;
          end else begin
            pulseCnt <= pulseCnt + 1'b1;
          end
        end
        RD_RELEASE: begin
          state      <= DONE;
          busy       <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
